// File: rtl/cpu_step_ctrl_pkg.sv
// Shared encodings for the debug run-control block: run-state codes and rate limits.
package cpu_step_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_BREAK = 2'b10
  } run_state_e;

  localparam logic [1:0] RATE_MAX = 2'd3;

  // Next run-rate index, wrapping back to the slowest rate after the fastest.
  function automatic logic [1:0] next_rate(input logic [1:0] rate);
    return (rate == RATE_MAX) ? 2'd0 : rate + 2'd1;
  endfunction

endpackage

// File: rtl/cpu_step_ctrl_if.sv
// Debug key/run-control bundle between the button front end, the CPU and the run controller.
interface cpu_step_ctrl_if #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 16
);

  logic             step_pulse;
  logic             run_pulse;
  logic             rate_pulse;
  logic             bp_en;
  logic [PC_W-1:0]  bp_addr;
  logic [PC_W-1:0]  pc;
  logic             cpu_en;
  logic [1:0]       state;
  logic [1:0]       rate_sel;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    output step_pulse, run_pulse, rate_pulse, bp_en, bp_addr, pc,
    input  cpu_en, state, rate_sel, instr_cnt
  );

  modport slave (
    input  step_pulse, run_pulse, rate_pulse, bp_en, bp_addr, pc,
    output cpu_en, state, rate_sel, instr_cnt
  );

endinterface

// File: rtl/cpu_step_rate_div.sv
// Run-rate divider: counts while running and flags a tick once every 2^(DIV_W-4*rate_sel) cycles.
module cpu_step_rate_div #(
  parameter int unsigned DIV_W = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       clear,
  input  logic [1:0] rate_sel,
  output logic       tick
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] mask;
  logic [3:0]       shamt;

  always_comb begin
    div_d = div_q;
    if (clear) begin
      div_d = '0;
    end else if (run) begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // Each rate step drops four divider bits from the tick compare, i.e. 16x faster.
  always_comb begin
    shamt = {rate_sel, 2'b00};
    mask  = {DIV_W{1'b1}} >> shamt;
    tick  = ((div_q & mask) == mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Debug run control: turns debounced key pulses into one-instruction CPU enables,
// with free-run at four rates, a PC breakpoint and an executed-instruction counter.
module cpu_step_ctrl
  import cpu_step_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W = 26,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 16
) (
  input logic            clk,
  input logic            rst,
  cpu_step_ctrl_if.slave dbg
);

  run_state_e       state_q, state_d;
  logic [1:0]       rate_q, rate_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             skip_q, skip_d;

  logic             tick;
  logic             div_run;
  logic             div_clear;
  logic [PC_W-1:0]  pc_cmp;
  logic [PC_W-1:0]  bp_cmp;
  logic             bp_hit;

  assign div_run   = (state_q == ST_RUN);
  assign div_clear = (state_q != ST_RUN) && (state_d == ST_RUN);

  cpu_step_rate_div #(
    .DIV_W (DIV_W)
  ) u_rate_div (
    .clk      (clk),
    .rst      (rst),
    .run      (div_run),
    .clear    (div_clear),
    .rate_sel (rate_q),
    .tick     (tick)
  );

  assign pc_cmp = dbg.pc;
  assign bp_cmp = dbg.bp_addr;
  assign bp_hit = dbg.bp_en && (pc_cmp == bp_cmp);

  // run_pulse is tested first in every state so it always beats a same-cycle step_pulse.
  always_comb begin
    state_d = state_q;
    en_d    = 1'b0;
    skip_d  = skip_q;
    rate_d  = dbg.rate_pulse ? next_rate(rate_q) : rate_q;

    unique case (state_q)
      ST_HALT: begin
        if (dbg.run_pulse) begin
          state_d = ST_RUN;
          skip_d  = 1'b1;
        end else if (dbg.step_pulse) begin
          en_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (dbg.run_pulse) begin
          state_d = ST_HALT;
        end else if (tick) begin
          // Stop in front of the breakpoint, unless we are resuming from it.
          if (bp_hit && !skip_q) begin
            state_d = ST_BREAK;
          end else begin
            en_d   = 1'b1;
            skip_d = 1'b0;
          end
        end
      end
      ST_BREAK: begin
        if (dbg.run_pulse) begin
          state_d = ST_RUN;
          skip_d  = 1'b1;
        end else if (dbg.step_pulse) begin
          en_d    = 1'b1;
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase

    cnt_d = cnt_q + CNT_W'(en_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HALT;
      rate_q  <= 2'd0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rate_q  <= rate_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      skip_q  <= skip_d;
    end
  end

  assign dbg.cpu_en    = en_q;
  assign dbg.state     = state_q;
  assign dbg.rate_sel  = rate_q;
  assign dbg.instr_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: directed scenarios plus random key traffic against a cycle model.
module tb_cpu_step_ctrl;

  localparam int unsigned DIV_W = 12;
  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_step_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W)) dbg ();

  // Toy CPU: PC advances by one instruction on each enable.
  logic [PC_W-1:0] pc_q;
  assign dbg.pc = pc_q;
  always @(posedge clk) begin
    if (rst) pc_q <= '0;
    else if (dbg.cpu_en) pc_q <= pc_q + 32'd4;
  end

  cpu_step_ctrl #(
    .DIV_W (DIV_W),
    .PC_W  (PC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .dbg (dbg)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: mode 0 halt / 1 run / 2 break; m_d counts cycles spent in RUN since entry.
  int m_mode = 0, m_d = 0, m_rate = 0, m_cnt = 0;
  bit m_en = 1'b0, m_skip = 1'b0;

  task automatic cyc(input bit s, input bit r, input bit t, input bit rs);
    int period;
    bit tick;
    int n_mode, n_d, n_rate, n_cnt;
    bit n_en, n_skip;
    dbg.step_pulse = s;
    dbg.run_pulse  = r;
    dbg.rate_pulse = t;
    rst            = rs;
    period = 1 << (DIV_W - 4 * m_rate);
    tick   = (m_mode == 1) && ((m_d % period) == period - 1);
    n_mode = m_mode;
    n_en   = 1'b0;
    n_skip = m_skip;
    n_rate = (m_rate + (t ? 1 : 0)) % 4;
    if (m_mode == 0) begin
      if (r) begin n_mode = 1; n_skip = 1'b1; end
      else if (s) n_en = 1'b1;
    end else if (m_mode == 1) begin
      if (r) n_mode = 0;
      else if (tick) begin
        if (dbg.bp_en && (dbg.pc == dbg.bp_addr) && !m_skip) n_mode = 2;
        else begin n_en = 1'b1; n_skip = 1'b0; end
      end
    end else begin
      if (r) begin n_mode = 1; n_skip = 1'b1; end
      else if (s) begin n_en = 1'b1; n_mode = 0; end
    end
    if (m_mode != 1 && n_mode == 1) n_d = 0;
    else if (m_mode == 1) n_d = (m_d + 1) % (1 << DIV_W);
    else n_d = m_d;
    n_cnt = (m_cnt + (n_en ? 1 : 0)) % (1 << CNT_W);
    if (rs) begin
      n_mode = 0; n_d = 0; n_rate = 0; n_cnt = 0; n_en = 1'b0; n_skip = 1'b0;
    end
    @(posedge clk);
    #1;
    m_mode = n_mode; m_d = n_d; m_rate = n_rate; m_cnt = n_cnt; m_en = n_en; m_skip = n_skip;
    dbg.step_pulse = 1'b0;
    dbg.run_pulse  = 1'b0;
    dbg.rate_pulse = 1'b0;
    rst            = 1'b0;
  endtask

  task automatic test_reset;
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    n_vec++; if (dbg.state !== 2'b00) begin n_err++;
      $display("FAIL reset_state: got %0b want 00", dbg.state); end
    n_vec++; if (dbg.rate_sel !== 2'd0) begin n_err++;
      $display("FAIL reset_rate: got %0d want 0", dbg.rate_sel); end
    n_vec++; if (dbg.instr_cnt !== 4'd0) begin n_err++;
      $display("FAIL reset_cnt: got %0d want 0", dbg.instr_cnt); end
    n_vec++; if (dbg.cpu_en !== 1'b0) begin n_err++;
      $display("FAIL reset_en: got %0b want 0", dbg.cpu_en); end
  endtask

  task automatic test_step;
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 0, 0);
      n_vec++; if (dbg.cpu_en !== 1'b1) begin n_err++;
        $display("FAIL step_en: step %0d got %0b want 1", k, dbg.cpu_en); end
      for (int j = 0; j < 4; j++) begin
        cyc(0, 0, 0, 0);
        n_vec++; if (dbg.cpu_en !== 1'b0) begin n_err++;
          $display("FAIL step_single: step %0d +%0d got %0b want 0", k, j, dbg.cpu_en); end
      end
    end
    n_vec++; if (dbg.instr_cnt !== 4'd3) begin n_err++;
      $display("FAIL step_cnt: got %0d want 3", dbg.instr_cnt); end
    n_vec++; if (dbg.state !== 2'b00) begin n_err++;
      $display("FAIL step_state: got %0b want 00", dbg.state); end
  endtask

  task automatic test_run_fast;
    for (int k = 0; k < 3; k++) cyc(0, 0, 1, 0);
    n_vec++; if (dbg.rate_sel !== 2'd3) begin n_err++;
      $display("FAIL fast_rate: got %0d want 3", dbg.rate_sel); end
    cyc(0, 1, 0, 0);
    n_vec++; if (dbg.state !== 2'b01) begin n_err++;
      $display("FAIL fast_state: got %0b want 01", dbg.state); end
    for (int k = 0; k < 8; k++) begin
      cyc(0, 0, 0, 0);
      n_vec++; if (dbg.cpu_en !== 1'b1) begin n_err++;
        $display("FAIL fast_en: cycle %0d got %0b want 1", k, dbg.cpu_en); end
    end
    cyc(0, 1, 0, 0);
    n_vec++; if (dbg.state !== 2'b00) begin n_err++;
      $display("FAIL fast_stop: got %0b want 00", dbg.state); end
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (dbg.cpu_en !== 1'b0) begin n_err++;
        $display("FAIL fast_after_stop: cycle %0d got %0b want 0", k, dbg.cpu_en); end
      cyc(0, 0, 0, 0);
    end
    n_vec++; if (dbg.instr_cnt !== 4'(m_cnt)) begin n_err++;
      $display("FAIL fast_cnt: got %0d want %0d", dbg.instr_cnt, m_cnt); end
  endtask

  task automatic test_rate_period;
    int q[$];
    for (int k = 0; k < 3; k++) cyc(0, 0, 1, 0);
    n_vec++; if (dbg.rate_sel !== 2'd2) begin n_err++;
      $display("FAIL period_rate: got %0d want 2", dbg.rate_sel); end
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 64; i++) begin
      cyc(0, 0, 0, 0);
      if (dbg.cpu_en === 1'b1) q.push_back(i);
    end
    n_vec++; if (q.size() != 4) begin n_err++;
      $display("FAIL period_count: got %0d want 4", q.size()); end
    for (int i = 0; i < q.size(); i++) begin
      n_vec++; if (q[i] != 15 + 16 * i) begin n_err++;
        $display("FAIL period_spacing: pulse %0d at %0d want %0d", i, q[i], 15 + 16 * i); end
    end
    cyc(0, 1, 0, 0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 1, 0);
    n_vec++; if (dbg.rate_sel !== 2'd2) begin n_err++;
      $display("FAIL period_wrap: got %0d want 2", dbg.rate_sel); end
  endtask

  task automatic test_breakpoint;
    int exp_pc[$];
    int got_pc[$];
    bit done;
    exp_pc = '{0, 4, 8, 12, 16, 20};
    cyc(0, 0, 0, 1);
    dbg.bp_en   = 1'b1;
    dbg.bp_addr = 32'h10;
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      cyc(0, 0, 0, 0);
      if (dbg.cpu_en === 1'b1) got_pc.push_back(int'(pc_q));
      if (dbg.state === 2'b10) done = 1'b1;
    end
    n_vec++; if (!done || dbg.state !== 2'b10) begin n_err++;
      $display("FAIL bp_break: got state %0b want 10", dbg.state); end
    n_vec++; if (pc_q !== 32'h10) begin n_err++;
      $display("FAIL bp_pc: got %0h want 10", pc_q); end
    cyc(0, 1, 0, 0);
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      cyc(0, 0, 0, 0);
      if (dbg.cpu_en === 1'b1) got_pc.push_back(int'(pc_q));
      if (pc_q === 32'h18) done = 1'b1;
    end
    n_vec++; if (!done || dbg.state !== 2'b01) begin n_err++;
      $display("FAIL bp_resume: got state %0b pc %0h want 01 pc 18", dbg.state, pc_q); end
    n_vec++; if (got_pc != exp_pc) begin n_err++;
      $display("FAIL bp_trace: got %p want %p", got_pc, exp_pc); end
    cyc(0, 1, 0, 0);
    dbg.bp_en = 1'b0;
  endtask

  task automatic test_step_run_same;
    bit done;
    logic [CNT_W-1:0] cnt0;
    cyc(0, 0, 0, 1);
    dbg.bp_en   = 1'b1;
    dbg.bp_addr = 32'h4;
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      cyc(0, 0, 0, 0);
      if (dbg.state === 2'b10) done = 1'b1;
    end
    n_vec++; if (!done) begin n_err++;
      $display("FAIL both_break: got state %0b want 10", dbg.state); end
    cnt0 = dbg.instr_cnt;
    cyc(1, 1, 0, 0);
    n_vec++; if (dbg.state !== 2'b01) begin n_err++;
      $display("FAIL both_state: got %0b want 01", dbg.state); end
    for (int k = 0; k < 3; k++) begin
      n_vec++; if (dbg.cpu_en !== 1'b0) begin n_err++;
        $display("FAIL both_no_step: cycle %0d got %0b want 0", k, dbg.cpu_en); end
      cyc(0, 0, 0, 0);
    end
    n_vec++; if (dbg.instr_cnt !== cnt0) begin n_err++;
      $display("FAIL both_cnt: got %0d want %0d", dbg.instr_cnt, cnt0); end
    cyc(0, 1, 0, 0);
    dbg.bp_en = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    bit done;
    cyc(0, 0, 0, 1);
    for (int k = 0; k < 3; k++) cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      cyc(0, 0, 0, 0);
      if (dbg.instr_cnt === 4'd5) done = 1'b1;
    end
    n_vec++; if (!done || dbg.state !== 2'b01) begin n_err++;
      $display("FAIL midrst_setup: got cnt %0d state %0b want 5 01", dbg.instr_cnt, dbg.state); end
    cyc(0, 0, 0, 1);
    n_vec++; if (dbg.state !== 2'b00 || dbg.instr_cnt !== 4'd0 || dbg.cpu_en !== 1'b0
                 || dbg.rate_sel !== 2'd0) begin n_err++;
      $display("FAIL midrst: got st %0b cnt %0d en %0b rate %0d want 00 0 0 0",
               dbg.state, dbg.instr_cnt, dbg.cpu_en, dbg.rate_sel); end
    cyc(0, 0, 0, 0);
    n_vec++; if (dbg.cpu_en !== 1'b0 || dbg.state !== 2'b00) begin n_err++;
      $display("FAIL midrst_after: got en %0b st %0b want 0 00", dbg.cpu_en, dbg.state); end
  endtask

  task automatic test_wrap;
    cyc(0, 0, 0, 1);
    for (int k = 0; k < 15; k++) begin
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
    end
    n_vec++; if (dbg.instr_cnt !== 4'd15) begin n_err++;
      $display("FAIL wrap_15: got %0d want 15", dbg.instr_cnt); end
    cyc(1, 0, 0, 0);
    n_vec++; if (dbg.instr_cnt !== 4'd0) begin n_err++;
      $display("FAIL wrap_0: got %0d want 0", dbg.instr_cnt); end
  endtask

  task automatic test_random;
    bit s, r, t, rs;
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) dbg.bp_en = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 49) == 0) dbg.bp_addr = 32'(4 * $urandom_range(0, 7));
      s  = ($urandom_range(0, 9) == 0);
      r  = ($urandom_range(0, 59) == 0);
      t  = ($urandom_range(0, 79) == 0);
      rs = ($urandom_range(0, 699) == 0);
      cyc(s, r, t, rs);
      n_vec++; if (dbg.cpu_en !== m_en) begin n_err++;
        $display("FAIL rand_en: cycle %0d got %0b want %0b", i, dbg.cpu_en, m_en); end
      n_vec++; if (dbg.state !== 2'(m_mode)) begin n_err++;
        $display("FAIL rand_state: cycle %0d got %0b want %0d", i, dbg.state, m_mode); end
      n_vec++; if (dbg.rate_sel !== 2'(m_rate)) begin n_err++;
        $display("FAIL rand_rate: cycle %0d got %0d want %0d", i, dbg.rate_sel, m_rate); end
      n_vec++; if (dbg.instr_cnt !== 4'(m_cnt)) begin n_err++;
        $display("FAIL rand_cnt: cycle %0d got %0d want %0d", i, dbg.instr_cnt, m_cnt); end
    end
    dbg.bp_en = 1'b0;
  endtask

  initial begin
    dbg.step_pulse = 1'b0;
    dbg.run_pulse  = 1'b0;
    dbg.rate_pulse = 1'b0;
    dbg.bp_en      = 1'b0;
    dbg.bp_addr    = '0;
    test_reset();
    test_step();
    test_run_fast();
    test_rate_period();
    test_breakpoint();
    test_step_run_same();
    test_reset_mid_run();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
